// File: rtl/sync_down_counter_pkg.sv
// Shared mode encodings and run/halt state type for the down counter.
// Imported by sync_down_counter and sync_down_prescaler.
package sync_down_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/sync_down_prescaler.sv
// Modulo-PRESCALE tick counter; tick marks the advancing cycle that closes a period.
// Used by sync_down_counter only when SYNC_DOWN_COUNTER_PRESCALE_EN is defined.
module sync_down_prescaler
  import sync_down_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic adv,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = adv && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_down_counter.sv
// WIDTH-bit down counter with parallel load and WRAP / RELOAD / ONESHOT modes.
// Optional prescaler enabled by defining SYNC_DOWN_COUNTER_PRESCALE_EN.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
`ifdef SYNC_DOWN_COUNTER_PRESCALE_EN
  ,
  parameter int               PRESCALE  = 4
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] Q,
  output logic             underflow,
  output logic             done,
  output logic             zero
);

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic             run_en;
  logic             step;

  assign run_en = en && (state == RUN);
  assign zero   = (Q == '0);

`ifdef SYNC_DOWN_COUNTER_PRESCALE_EN
  // Load wins over en, so the prescaler must not advance on a load cycle.
  sync_down_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (load),
    .adv    (run_en && !load),
    .tick   (step)
  );
`else
  assign step = run_en;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q          <= RESET_VAL;
      reload_reg <= RESET_VAL;
      state      <= RUN;
      underflow  <= 1'b0;
      done       <= 1'b0;
    end else if (load) begin
      Q          <= load_val;
      reload_reg <= load_val;
      state      <= RUN;
      underflow  <= 1'b0;
      done       <= 1'b0;
    end else if (step) begin
      if (Q != '0) begin
        Q         <= Q - 1'b1;
        underflow <= 1'b0;
      end else begin
        // Zero crossing: the terminal-count event, mode selects the follow-up.
        underflow <= 1'b1;
        case (mode)
          MODE_RELOAD:  Q <= reload_reg;
          MODE_ONESHOT: begin
            state <= HALT;
            done  <= 1'b1;
          end
          default:      Q <= {WIDTH{1'b1}};
        endcase
      end
    end else begin
      underflow <= 1'b0;
    end
  end

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
- Synchronous WIDTH-bit down counter with parallel load, three count modes (wrap, auto-reload, one-shot) and registered underflow/done flags.
- Counterpart to the team's synchronous up counter: counts the opposite direction and produces the terminal-count events that timers and timeouts consume.
- One clock domain; sits beside the up counter in the basic-blocks library.

Parameters:
- WIDTH, 4, counter width in bits (must be ≥ 2).
- RESET_VAL, {WIDTH{1'b1}}, value of Q and of the reload register after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; one decrement per enabled cycle.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded into Q and into the reload register.
- mode  input  2  00 = WRAP, 01 = RELOAD, 10 = ONESHOT, 11 = reserved (behaves as WRAP).
- Q  output  WIDTH  current count, registered.
- underflow  output  1  one-cycle registered pulse on each zero-crossing event.
- done  output  1  sticky; high while halted in ONESHOT.
- zero  output  1  combinational, Q == 0.

Behaviour:
- Reset (asynchronous, at any time including mid-count):
  - Q = RESET_VAL, reload_reg = RESET_VAL.
  - State = RUN.
  - underflow = 0, done = 0.
- Clock edge, priority high to low: load > en > hold.
- load = 1:
  - Q ← load_val, reload_reg ← load_val.
  - State ← RUN, done ← 0, underflow ← 0.
  - en is ignored that cycle.
- RUN, en = 1, Q != 0: Q ← Q − 1, underflow ← 0.
- RUN, en = 1, Q == 0 (the zero-crossing event; underflow ← 1 for exactly one cycle):
  - WRAP: Q ← {WIDTH{1'b1}}.
  - RELOAD: Q ← reload_reg. If reload_reg == 0, Q stays 0 and underflow pulses every enabled cycle.
  - ONESHOT: Q holds 0, state ← HALT, done ← 1.
- RUN, en = 0: Q holds, underflow ← 0.
- HALT:
  - Q holds 0, done stays 1, underflow = 0.
  - en has no effect.
  - Only load or reset leaves HALT.
- A mode change takes effect on the next edge and does not itself alter Q.
- Changing mode away from ONESHOT while in HALT does not release HALT; a load is required.
- Latency:
  - Q updates one clock after a qualifying en or load.
  - underflow is asserted in the cycle after the edge on which Q == 0 was consumed.
- Widths: all arithmetic is modulo 2^WIDTH; there is no sign bit.

Optional Feature:
- Macro: SYNC_DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 4, ≥ 1) and an internal modulo-PRESCALE tick counter.
  - The tick counter advances on en = 1 in RUN.
  - Q decrements (or takes its zero-crossing action) only on the enabled cycle where the tick counter reaches PRESCALE − 1.
  - The tick counter resets to 0 on reset and on load, and holds in HALT.
  - PRESCALE = 1 is identical to the undefined build.
- Undefined: no prescaler logic; every enabled cycle in RUN is a count step.

Decomposition:
- Package sync_down_counter_pkg:
  - mode encodings MODE_WRAP = 2'b00, MODE_RELOAD = 2'b01, MODE_ONESHOT = 2'b10.
  - state typedef (RUN, HALT).
- Sub-module sync_down_prescaler (tick counter with clear and enable, tick output), instantiated only under SYNC_DOWN_COUNTER_PRESCALE_EN.

Test Plan:
- Reset then WRAP: clk period 50 ns, reset_n = 0 for 100 ns, then en = 1, mode = 00, WIDTH = 4 → Q counts F, E, …, 0, F. underflow pulses once per 16 cycles, in the cycle Q shows F after 0.
- RELOAD: load_val = 5, then en = 1, mode = 01 → Q = 5, 4, 3, 2, 1, 0, 5, 4 … with underflow high for one cycle each time Q returns to 5. Repeat with load_val = 0 → Q stays 0 and underflow is high every enabled cycle.
- ONESHOT: load_val = 3, mode = 10, en = 1 → Q = 3, 2, 1, 0, then hold 0. done = 1 and stays 1 over 10 more enabled cycles. underflow pulses exactly once. A subsequent load_val = 2 clears done and resumes counting.
- Priority: Q = 7, assert load = 1 with load_val = 9 and en = 1 in the same cycle → Q = 9 next cycle, not 8. Also deassert en for 3 cycles mid-count → Q holds.
- Async reset mid-operation: during ONESHOT HALT with done = 1, pulse reset_n low for 10 ns between clock edges → Q = RESET_VAL, done = 0 and underflow = 0 immediately, without waiting for a clock edge.
- Prescale build: define SYNC_DOWN_COUNTER_PRESCALE_EN with PRESCALE = 4, load_val = 2, mode = 01 → Q steps every 4th enabled cycle: 2 ×4, 1 ×4, 0 ×4, 2. A load at tick 2 restarts the prescale count.
